mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles in REQ+WAIT before abort (range 1..255).
REQ-002 Port clk input 1: single clock; all state on rising edge.
REQ-003 Port rst_n input 1: reset, asynchronous, active-low.
REQ-004 Port memread_ex_mem input 1: EX/MEM stage holds a load.
REQ-005 Port memwrite_ex_mem input 1: EX/MEM stage holds a store.
REQ-006 Port addr_ex_mem input 32: access address.
REQ-007 Port wdata_ex_mem input 32: store data.
REQ-008 Port dmem_req output 1: data-memory request, level, held until ack.
REQ-009 Port dmem_we output 1: 1 = write, 0 = read.
REQ-010 Ports dmem_addr output 32, dmem_wdata output 32: latched request address/data.
REQ-011 Port dmem_ack input 1: memory completion, one-cycle pulse.
REQ-012 Port dmem_rdata input 32: read data, valid with dmem_ack.
REQ-013 Port rdata_mem_wb output 32: captured load data for MEM/WB.
REQ-014 Port mem_busy output 1: stall request to pipeline; pipeline frozen while 1.
REQ-015 Port mem_done output 1: one-cycle completion pulse.
REQ-016 Port mem_err output 1: one-cycle timeout pulse.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE with memread_ex_mem or memwrite_ex_mem high SHALL latch addr/wdata/we and go to REQ next edge.
REQ-019 Both read and write high SHALL be treated as a write.
REQ-020 REQ SHALL assert dmem_req; dmem_ack in REQ -> DONE, else -> WAIT.
REQ-021 WAIT SHALL keep dmem_req high with addr/wdata/we stable until dmem_ack -> DONE.
REQ-022 On dmem_ack of a read, rdata_mem_wb SHALL load dmem_rdata; on a write it SHALL hold its value.
REQ-023 DONE SHALL last exactly one cycle, pulse mem_done, deassert dmem_req, ignore inputs, and return to IDLE.
REQ-024 mem_busy SHALL be combinational: 1 in IDLE when a memory op is present, 1 in REQ and WAIT, 0 in DONE and idle-without-op.
REQ-025 Minimum latency: op visible cycle 0, dmem_req cycle 1, ack cycle 1 -> mem_done cycle 2, mem_busy high cycles 0-1.
REQ-026 dmem_ack outside REQ/WAIT SHALL be ignored.
REQ-027 The op held in EX/MEM during DONE SHALL NOT be re-issued.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, rdata_mem_wb 0, mem_done 0, mem_err 0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL abandon it; a late dmem_ack afterwards SHALL be ignored.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and increment each REQ/WAIT cycle; reaching TIMEOUT_CYCLES without ack SHALL go to DONE with mem_done and mem_err pulsed together, rdata_mem_wb set to 0.
REQ-031 Without MEM_TIMEOUT_EN, no counter SHALL exist, mem_err SHALL be tied 0, and WAIT SHALL persist until dmem_ack.

Verification
REQ-032 Load addr 0x100, ack in REQ with rdata 0xDEADBEEF -> dmem_req cycle 1, mem_done cycle 2, rdata_mem_wb=0xDEADBEEF, mem_busy high cycles 0-1.
REQ-033 Store addr 0x200 wdata 0x12345678, ack after 5 WAIT cycles -> dmem_we=1, addr/wdata stable all 6 request cycles, rdata_mem_wb unchanged.
REQ-034 Read and write both high -> dmem_we=1 issued once; op still present in DONE not re-issued.
REQ-035 rst_n low during WAIT, then ack -> all outputs 0 immediately, ack ignored, state IDLE.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_err and mem_done pulse after 4 request cycles, rdata_mem_wb=0; without macro, mem_busy stays 1 until ack.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory handshake controller: issues one request per load/store and stalls the pipeline until it completes.
// Optional request timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread_ex_mem,
    input  logic        memwrite_ex_mem,
    input  logic [31:0] addr_ex_mem,
    input  logic [31:0] wdata_ex_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata_mem_wb,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   op_present;
    logic   in_request;
    logic   timeout_hit;

    assign op_present = memread_ex_mem | memwrite_ex_mem;
    assign in_request = (state == REQ) || (state == WAIT);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Counter holds the number of request cycles already spent, so the
    // TIMEOUT_CYCLES-th request cycle sees TIMEOUT_CYCLES-1.
    assign timeout_hit = in_request && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && op_present)
                tmo_cnt <= '0;
            else if (in_request)
                tmo_cnt <= tmo_cnt + 8'd1;
            err_q <= timeout_hit && !dmem_ack;
        end
    end

    assign mem_err = err_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (op_present) state_nxt = REQ;
            REQ, WAIT: begin
                if (dmem_ack || timeout_hit)
                    state_nxt = DONE;
                else
                    state_nxt = WAIT;
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            rdata_mem_wb <= '0;
        end else begin
            if (state == IDLE && op_present) begin
                dmem_we    <= memwrite_ex_mem;
                dmem_addr  <= addr_ex_mem;
                dmem_wdata <= wdata_ex_mem;
            end
            if (in_request && dmem_ack) begin
                if (!dmem_we)
                    rdata_mem_wb <= dmem_rdata;
            end else if (timeout_hit) begin
                rdata_mem_wb <= '0;
            end
        end
    end

    assign dmem_req = in_request;
    assign mem_done = (state == DONE);
    assign mem_busy = in_request || (state == IDLE && op_present);

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed scenarios plus randomized
// loads/stores checked against a transaction-level model of the handshake.
module tb_mem_stall_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread_ex_mem, memwrite_ex_mem;
    logic [31:0] addr_ex_mem, wdata_ex_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] rdata_mem_wb;
    logic        mem_busy, mem_done, mem_err;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] m_rdata;

    mem_stall_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .memread_ex_mem(memread_ex_mem), .memwrite_ex_mem(memwrite_ex_mem),
        .addr_ex_mem(addr_ex_mem), .wdata_ex_mem(wdata_ex_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rdata_mem_wb(rdata_mem_wb),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One load/store seen from EX/MEM; waits = WAIT cycles before ack.
    // Cycle 0: op visible; cycles 1..n_req: request; then DONE; then IDLE.
    task automatic run_op(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdv, input int waits);
        logic        tmo;
        int          n_req;
        logic [69:0] obs, exp;
        if (TMO != 0 && waits + 1 > TMO) begin
            tmo = 1'b1; n_req = TMO;
        end else begin
            tmo = 1'b0; n_req = waits + 1;
        end
        memread_ex_mem = rd; memwrite_ex_mem = wr;
        addr_ex_mem = a; wdata_ex_mem = wd; dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1;
        tests++;
        if ({dmem_req, mem_busy, mem_done, mem_err} !== 4'b0100) begin
            fails++;
            $display("FAIL %s issue: req/busy/done/err=%b want 0100", name,
                     {dmem_req, mem_busy, mem_done, mem_err});
        end
        next_cycle();
        for (int c = 1; c <= n_req; c++) begin
            dmem_ack = (!tmo && c == n_req);
            dmem_rdata = dmem_ack ? rdv : $urandom;
            addr_ex_mem = $urandom; wdata_ex_mem = $urandom;
            #1;
            obs = {dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_busy, mem_done, mem_err};
            exp = {1'b1, wr, a, wd, 1'b1, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s req_cycle%0d: got %h want %h", name, c, obs, exp);
            end
            next_cycle();
        end
        if (tmo) m_rdata = '0;
        else if (!wr) m_rdata = rdv;
        // DONE: op still held and a stray ack must both be ignored
        dmem_ack = 1'b1; dmem_rdata = $urandom; addr_ex_mem = $urandom;
        #1;
        tests++;
        if ({dmem_req, mem_busy, mem_done, mem_err, rdata_mem_wb} !== {3'b001, tmo, m_rdata}) begin
            fails++;
            $display("FAIL %s done: req/busy/done/err=%b rdata=%h want %b %h", name,
                     {dmem_req, mem_busy, mem_done, mem_err}, rdata_mem_wb, {3'b001, tmo}, m_rdata);
        end
        next_cycle();
        memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0; dmem_ack = 1'b0;
        #1;
        tests++;
        if ({dmem_req, mem_busy, mem_done, mem_err, rdata_mem_wb} !== {4'b0000, m_rdata}) begin
            fails++;
            $display("FAIL %s after_done: req/busy/done/err=%b rdata=%h want 0000 %h", name,
                     {dmem_req, mem_busy, mem_done, mem_err}, rdata_mem_wb, m_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
        addr_ex_mem = '0; wdata_ex_mem = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        m_rdata = '0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_mem_wb, mem_busy, mem_done, mem_err} !== '0) begin
            fails++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h rdata=%h busy=%b done=%b err=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_mem_wb, mem_busy, mem_done, mem_err);
        end
    endtask

    task automatic test_load();
        run_op("load_min", 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_store();
        run_op("store_wait", 1'b0, 1'b1, 32'h200, 32'h12345678, 32'hCAFEF00D, (TMO != 0) ? TMO - 2 : 5);
    endtask

    task automatic test_read_write_both();
        run_op("rd_wr_both", 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 32'h0BADBAD0, 1);
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom;
            #1;
            tests++;
            if ({dmem_req, mem_busy, mem_done, rdata_mem_wb} !== {3'b000, m_rdata}) begin
                fails++;
                $display("FAIL idle_ack%0d: req/busy/done=%b rdata=%h want 000 %h", i,
                         {dmem_req, mem_busy, mem_done}, rdata_mem_wb, m_rdata);
            end
            next_cycle();
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        memread_ex_mem = 1'b1; addr_ex_mem = 32'h400; dmem_ack = 1'b0;
        next_cycle();
        next_cycle();
        memread_ex_mem = 1'b0;
        rst_n = 1'b0;
        m_rdata = '0;
        #1;
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_mem_wb, mem_busy, mem_done, mem_err} !== '0) begin
            fails++;
            $display("FAIL reset_mid: req=%b we=%b addr=%h wdata=%h rdata=%h busy=%b done=%b err=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_mem_wb, mem_busy, mem_done, mem_err);
        end
        next_cycle();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
        next_cycle();
        dmem_ack = 1'b0;
        #1;
        tests++;
        if ({dmem_req, mem_busy, mem_done, mem_err, rdata_mem_wb} !== 36'h0) begin
            fails++;
            $display("FAIL late_ack: req/busy/done/err=%b rdata=%h want 0000 0",
                     {dmem_req, mem_busy, mem_done, mem_err}, rdata_mem_wb);
        end
    endtask

    task automatic test_timeout();
        run_op("timeout", 1'b1, 1'b0, 32'h500, 32'h0, 32'h77777777, 20);
    endtask

    task automatic test_random();
        logic rd, wr;
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            run_op("random", rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_read_write_both();
        test_idle_ack();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
